// File: rtl/dbus_pkg.sv
// dbus_pkg: shared encodings for the data bus access unit.
//   - bus mode (idle/read/write), access width, fault codes
//   - FSM state enum
//   - is_misaligned(): alignment rule for a given width and low address bits
package dbus_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_READ  = 2'b01,
        MODE_WRITE = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        W_BYTE    = 2'b00,
        W_HALF    = 2'b01,
        W_WORD    = 2'b10,
        W_ILLEGAL = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_TIMEOUT  = 2'b10,
        FLT_ILLEGAL  = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    // Byte is always aligned; half needs addr[0]=0; word needs addr[1:0]=00.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        case (width)
            W_HALF:  return addr_lo[0];
            W_WORD:  return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_bus_access_unit_if.sv
// data_bus_access_unit_if: word-oriented data bus between the access unit
// (master) and the memory slave.
//   data_bus_addr  : word-aligned address
//   data_bus_mode  : 00 idle, 01 read, 10 write
//   data_bus_be    : byte enables, bit n = lane n
//   data_bus_wdata : lane-positioned store data
//   data_bus_rdata : read data, valid with ack
//   data_bus_ack   : single-cycle completion pulse from the slave
interface data_bus_access_unit_if #(parameter int ADDR_W = 32);
    logic [ADDR_W-1:0] data_bus_addr;
    logic [1:0]        data_bus_mode;
    logic [3:0]        data_bus_be;
    logic [31:0]       data_bus_wdata;
    logic [31:0]       data_bus_rdata;
    logic              data_bus_ack;

    modport master (
        output data_bus_addr, data_bus_mode, data_bus_be, data_bus_wdata,
        input  data_bus_rdata, data_bus_ack
    );

    modport slave (
        input  data_bus_addr, data_bus_mode, data_bus_be, data_bus_wdata,
        output data_bus_rdata, data_bus_ack
    );
endinterface

// File: rtl/dbus_lane_align.sv
// dbus_lane_align: combinational byte-lane logic.
//   mode, width, addr_lo : latched access descriptor
//   load_signed          : sign-extend the extracted load value
//   store_data           : right-aligned store data
//   rdata                : raw bus read data
//   be                   : byte enables (0 when mode is idle)
//   wdata                : replicated store data (0 unless writing)
//   load_data            : lane-selected, extended load value
module dbus_lane_align
    import dbus_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [1:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic        load_signed,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        be        = 4'b0000;
        wdata     = 32'h0;
        load_data = 32'h0;

        case (addr_lo)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        if (mode != MODE_IDLE) begin
            case (width)
                W_BYTE:  be = 4'b0001 << addr_lo;
                W_HALF:  be = 4'b0011 << {addr_lo[1], 1'b0};
                W_WORD:  be = 4'b1111;
                default: be = 4'b0000;
            endcase
        end

        // Replicating across lanes lets the slave pick any lane with be alone.
        if (mode == MODE_WRITE) begin
            case (width)
                W_BYTE:  wdata = {4{store_data[7:0]}};
                W_HALF:  wdata = {2{store_data[15:0]}};
                W_WORD:  wdata = store_data;
                default: wdata = 32'h0;
            endcase
        end

        case (width)
            W_BYTE:  load_data = {{24{load_signed & rd_byte[7]}}, rd_byte};
            W_HALF:  load_data = {{16{load_signed & rd_half[15]}}, rd_half};
            W_WORD:  load_data = rdata;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_bus_access_unit.sv
// data_bus_access_unit: turns a core load/store request into one data bus
// transaction with alignment checks, lane steering and a wait timeout.
//   clk, reset              : clock, synchronous active-high reset
//   cs_bus_read/write       : request strobes (write wins when both high)
//   cs_mem_width            : 00 byte, 01 half, 10 word, 11 illegal
//   cs_load_signed          : sign-extend load result
//   addr_in, data_in        : byte address, right-aligned store data
//   data_out                : load result, nonzero only in DONE after a good read
//   stall                   : hold the core instruction
//   fault, fault_code       : access outcome, valid only in DONE
//   dbus                    : data bus master port
module data_bus_access_unit
    import dbus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_bus_read,
    input  logic              cs_bus_write,
    input  logic [1:0]        cs_mem_width,
    input  logic              cs_load_signed,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              stall,
    output logic              fault,
    output logic [1:0]        fault_code,
    data_bus_access_unit_if.master dbus
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_inc;
    logic [1:0]        mode_q, width_q, code_q;
    logic              signed_q, fault_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       sdata_q, data_q, load_data;

    logic req, bad_width, bad_align, to_hit;

    assign req       = cs_bus_read | cs_bus_write;
    assign bad_width = cs_mem_width == W_ILLEGAL;
    assign bad_align = is_misaligned(cs_mem_width, addr_in[1:0]);
    assign cnt_inc   = cnt_q + 1'b1;
    // Fires in the ACCESS cycle whose missing ack would bring the count to
    // TIMEOUT, so exactly TIMEOUT ACCESS cycles elapse before abort.
    assign to_hit    = (TIMEOUT != 0) && !dbus.data_bus_ack && (cnt_inc == TO_VAL);

    dbus_lane_align u_lane (
        .mode        (mode_q),
        .width       (width_q),
        .addr_lo     (addr_q[1:0]),
        .load_signed (signed_q),
        .store_data  (sdata_q),
        .rdata       (dbus.data_bus_rdata),
        .be          (dbus.data_bus_be),
        .wdata       (dbus.data_bus_wdata),
        .load_data   (load_data)
    );

    // mode_q is only nonzero during ACCESS, so it also gates the address.
    assign dbus.data_bus_mode = mode_q;
    assign dbus.data_bus_addr = (mode_q != MODE_IDLE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign data_out           = data_q;
    assign fault              = fault_q;
    assign fault_code         = code_q;

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    stall   = 1'b1;
                    state_d = (bad_width || bad_align) ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                stall = 1'b1;
                if (dbus.data_bus_ack || to_hit) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mode_q   <= MODE_IDLE;
            width_q  <= W_BYTE;
            signed_q <= 1'b0;
            addr_q   <= '0;
            sdata_q  <= 32'h0;
            data_q   <= 32'h0;
            fault_q  <= 1'b0;
            code_q   <= FLT_NONE;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        addr_q   <= addr_in;
                        width_q  <= cs_mem_width;
                        signed_q <= cs_load_signed;
                        sdata_q  <= data_in;
                        cnt_q    <= '0;
                        if (bad_width) begin
                            fault_q <= 1'b1;
                            code_q  <= FLT_ILLEGAL;
                        end else if (bad_align) begin
                            fault_q <= 1'b1;
                            code_q  <= FLT_MISALIGN;
                        end else begin
                            mode_q <= cs_bus_write ? MODE_WRITE : MODE_READ;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (dbus.data_bus_ack) begin
                        mode_q <= MODE_IDLE;
                        data_q <= (mode_q == MODE_READ) ? load_data : 32'h0;
                    end else if (to_hit) begin
                        mode_q  <= MODE_IDLE;
                        fault_q <= 1'b1;
                        code_q  <= FLT_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    // DONE lasts one cycle; drop the result so it is only seen there.
                    data_q  <= 32'h0;
                    fault_q <= 1'b0;
                    code_q  <= FLT_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_access_unit.sv
module tb_data_bus_access_unit;
    import dbus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_bus_read, cs_bus_write, cs_load_signed;
    logic [1:0]  cs_mem_width;
    logic [31:0] addr_in, data_in, data_out;
    logic        stall, fault;
    logic [1:0]  fault_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_bus_access_unit_if #(.ADDR_W(32)) dbus ();

    data_bus_access_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .cs_bus_read    (cs_bus_read),
        .cs_bus_write   (cs_bus_write),
        .cs_mem_width   (cs_mem_width),
        .cs_load_signed (cs_load_signed),
        .addr_in        (addr_in),
        .data_in        (data_in),
        .data_out       (data_out),
        .stall          (stall),
        .fault          (fault),
        .fault_code     (fault_code),
        .dbus           (dbus)
    );

    typedef struct {
        logic        rd, wr;
        logic [1:0]  width;
        logic        sgn;
        logic [31:0] addr, din, rdata;
        int          waits;      // ACCESS cycles before the ack cycle
        logic        noack;      // never ack: expect timeout
        logic [1:0]  exp_mode;   // 00 means no bus cycle
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_dout;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cs_bus_read    = 1'b0;
        cs_bus_write   = 1'b0;
        cs_mem_width   = 2'b00;
        cs_load_signed = 1'b0;
        addr_in        = 32'h0;
        data_in        = 32'h0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        cs_bus_read    = v.rd;
        cs_bus_write   = v.wr;
        cs_mem_width   = v.width;
        cs_load_signed = v.sgn;
        addr_in        = v.addr;
        data_in        = v.din;
        dbus.data_bus_rdata = v.rdata;
        #1;
        chk($sformatf("v%0d_stall_req", idx), {31'h0, stall}, 32'h1);
        chk($sformatf("v%0d_mode_req", idx), {30'h0, dbus.data_bus_mode}, 32'h0);
        @(negedge clk);
        idle_inputs();
        if (v.exp_mode != 2'b00) begin
            for (int w = 0; w <= v.waits; w++) begin
                chk($sformatf("v%0d_c%0d_mode", idx, w), {30'h0, dbus.data_bus_mode}, {30'h0, v.exp_mode});
                chk($sformatf("v%0d_c%0d_be", idx, w), {28'h0, dbus.data_bus_be}, {28'h0, v.exp_be});
                chk($sformatf("v%0d_c%0d_wdata", idx, w), dbus.data_bus_wdata, v.exp_wdata);
                chk($sformatf("v%0d_c%0d_addr", idx, w), dbus.data_bus_addr, v.addr & 32'hFFFF_FFFC);
                chk($sformatf("v%0d_c%0d_stall", idx, w), {31'h0, stall}, 32'h1);
                if (w == v.waits && !v.noack) dbus.data_bus_ack = 1'b1;
                @(negedge clk);
                dbus.data_bus_ack = 1'b0;
            end
        end
        // DONE cycle
        chk($sformatf("v%0d_done_stall", idx), {31'h0, stall}, 32'h0);
        chk($sformatf("v%0d_done_mode", idx), {30'h0, dbus.data_bus_mode}, 32'h0);
        chk($sformatf("v%0d_done_fault", idx), {31'h0, fault}, {31'h0, v.exp_code != 2'b00});
        chk($sformatf("v%0d_done_code", idx), {30'h0, fault_code}, {30'h0, v.exp_code});
        chk($sformatf("v%0d_done_dout", idx), data_out, v.exp_dout);
        @(negedge clk);
        chk($sformatf("v%0d_post_fault", idx), {31'h0, fault}, 32'h0);
        chk($sformatf("v%0d_post_dout", idx), data_out, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rd    wr    width sgn   addr          din           rdata         w  na    mode   be       wdata         dout          code
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0,        32'h8012_3456, 0, 1'b0, 2'b01, 4'b1000, 32'h0,        32'hFFFF_FF80, 2'b00};
        vecs[1]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 32'h0,        2, 1'b0, 2'b10, 4'b1100, 32'hBEEF_BEEF, 32'h0,        2'b00};
        vecs[2]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0,        32'h0,        0, 1'b0, 2'b00, 4'b0000, 32'h0,        32'h0,        2'b01};
        vecs[3]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0,        32'h1111_2222, 3, 1'b1, 2'b01, 4'b1111, 32'h0,        32'h0,        2'b10};
        vecs[4]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4004, 32'h0,        32'hCAFE_F00D, 3, 1'b0, 2'b01, 4'b1111, 32'h0,        32'hCAFE_F00D, 2'b00};
        vecs[5]  = '{1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_5001, 32'h0,        32'h0,        0, 1'b0, 2'b00, 4'b0000, 32'h0,        32'h0,        2'b11};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'h0,        32'h1234_ABCD, 0, 1'b0, 2'b01, 4'b0010, 32'h0,        32'h0000_00AB, 2'b00};
        vecs[7]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'h0,        32'h8001_7FFF, 1, 1'b0, 2'b01, 4'b1100, 32'h0,        32'hFFFF_8001, 2'b00};
        vecs[8]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_1000, 32'h0,        32'h8001_F00F, 0, 1'b0, 2'b01, 4'b0011, 32'h0,        32'h0000_F00F, 2'b00};
        vecs[9]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_6001, 32'h1234_565A, 32'h0,        0, 1'b0, 2'b10, 4'b0010, 32'h5A5A_5A5A, 32'h0,        2'b00};
        vecs[10] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_7000, 32'hDEAD_BEEF, 32'h0,        1, 1'b0, 2'b10, 4'b1111, 32'hDEAD_BEEF, 32'h0,        2'b00};
        vecs[11] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2001, 32'h0000_1234, 32'h0,        0, 1'b0, 2'b00, 4'b0000, 32'h0,        32'h0,        2'b01};
        vecs[12] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_8000, 32'h0102_0304, 32'hFFFF_FFFF, 0, 1'b0, 2'b10, 4'b1111, 32'h0102_0304, 32'h0,        2'b00};
        vecs[13] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1000, 32'h0,        32'hFFFF_FF7F, 0, 1'b0, 2'b01, 4'b0001, 32'h0,        32'h0000_007F, 2'b00};

        idle_inputs();
        dbus.data_bus_rdata = 32'h0;
        dbus.data_bus_ack   = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mode",  {30'h0, dbus.data_bus_mode}, 32'h0);
        chk("rst_be",    {28'h0, dbus.data_bus_be}, 32'h0);
        chk("rst_wdata", dbus.data_bus_wdata, 32'h0);
        chk("rst_addr",  dbus.data_bus_addr, 32'h0);
        chk("rst_dout",  data_out, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_code",  {30'h0, fault_code}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Ack while IDLE must not start or complete anything.
        @(negedge clk);
        dbus.data_bus_ack = 1'b1;
        @(negedge clk);
        dbus.data_bus_ack = 1'b0;
        chk("idle_ack_stall", {31'h0, stall}, 32'h0);
        chk("idle_ack_fault", {31'h0, fault}, 32'h0);
        chk("idle_ack_dout",  data_out, 32'h0);

        // Request held through DONE is ignored there; DONE returns to IDLE.
        @(negedge clk);
        cs_bus_read = 1'b1; cs_mem_width = 2'b10; addr_in = 32'h0000_A002;
        @(negedge clk);
        chk("hold_done_stall", {31'h0, stall}, 32'h0);
        chk("hold_done_code",  {30'h0, fault_code}, 32'h1);
        dbus.data_bus_ack = 1'b1;
        @(negedge clk);
        dbus.data_bus_ack = 1'b0;
        chk("hold_idle_mode",  {30'h0, dbus.data_bus_mode}, 32'h0);
        chk("hold_idle_fault", {31'h0, fault}, 32'h0);
        idle_inputs();
        @(negedge clk);

        // Reset mid-ACCESS abandons the access; a late ack is ignored.
        cs_bus_read = 1'b1; cs_mem_width = 2'b10; addr_in = 32'h0000_9000;
        dbus.data_bus_rdata = 32'h5555_AAAA;
        @(negedge clk);
        idle_inputs();
        chk("rmid_access_mode", {30'h0, dbus.data_bus_mode}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rmid_mode",  {30'h0, dbus.data_bus_mode}, 32'h0);
        chk("rmid_stall", {31'h0, stall}, 32'h0);
        dbus.data_bus_ack = 1'b1;
        @(negedge clk);
        dbus.data_bus_ack = 1'b0;
        chk("rmid_late_fault", {31'h0, fault}, 32'h0);
        chk("rmid_late_dout",  data_out, 32'h0);
        chk("rmid_late_mode",  {30'h0, dbus.data_bus_mode}, 32'h0);
        @(negedge clk);
        chk("rmid_after_fault", {31'h0, fault}, 32'h0);
        chk("rmid_after_stall", {31'h0, stall}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
